sm_subtractor_pipe: RTL and testbench
=====================================

// Module: sm_subtractor_pipe
// PURPOSE
//  Pipelined sign-magnitude fixed-point subtractor: OUTPUT = INPUT0 - INPUT1.
//  Counterpart of the combinational adder in the 32-point FFT butterfly. It supplies
//  the difference leg (a - b*W) as a registered, flow-controlled stage.
//  Number format throughout: bit [bits-1] = sign, [bits-2:0] = magnitude, fix_bit fractional bits.
// PARAMETERS
//  fix_bit  7   fractional bits of magnitude (format only; no effect on arithmetic)
//  bits     16  total word width incl. sign bit (>= 4)
// PORTS
//  CLK        in   1     clock; all state updates on rising edge
//  RST        in   1     reset, synchronous, active-high
//  IN_VALID   in   1     operand pair valid
//  IN_READY   out  1     block can accept operand pair this cycle
//  INPUT0     in   bits  minuend, sign-magnitude
//  INPUT1     in   bits  subtrahend, sign-magnitude
//  OUT_VALID  out  1     OUTPUT/SAT valid
//  OUT_READY  in   1     downstream accepts OUTPUT this cycle
//  OUTPUT     out  bits  difference, sign-magnitude
//  SAT        out  1     result was clipped to full-scale magnitude
// BEHAVIOUR
//  Reset: on RST=1 at a clock edge, both stage-valid flags clear; OUT_VALID=0, SAT=0,
//   OUTPUT=0 on the next cycle; in-flight data is dropped. IN_READY=1 while RST=1.
//  Handshake: transfer in when IN_VALID&IN_READY; transfer out when OUT_VALID&OUT_READY.
//   OUTPUT/SAT stay stable while OUT_VALID=1 and OUT_READY=0. Order is preserved. No drops.
//  Pipeline: 2 register stages (S1 arithmetic, S2 packing). Latency = 2 cycles from
//   accept edge to OUT_VALID=1 with no backpressure. Throughput = 1 pair/cycle.
//   S2 loads when S1 valid and (S2 empty or OUT_READY).
//   S1 loads when (S1 empty or S1 moving into S2).
//   IN_READY = !S1_V | !S2_V | OUT_READY (combinational). Capacity = 2 entries.
//  S1 arithmetic: convert each operand to two's complement, width bits+1:
//   tc = sign ? -mag : +mag. Negative zero (sign=1, mag=0) converts to 0.
//   Register d = tc0 - tc1 at width bits+1. It cannot overflow: |d| <= 2*(2^(bits-1)-1).
//  S2 packing: mag = |d|. If mag > 2^(bits-1)-1, clip mag to 2^(bits-1)-1 and set SAT=1.
//   Otherwise SAT=0. Sign = (d<0). Zero result is always emitted as +0 (all bits 0).
//  Simultaneous accept and emit with both stages full: pipeline shifts, no bubble.
//  Stream is held off indefinitely while OUT_READY=0. The block holds 2 pairs, then
//   IN_READY=0.
//  RST asserted together with IN_VALID: no transfer occurs.
// STRUCTURE
//  Shared package fft_fixed_pkg: BITS/FIX_BIT defaults, SM_MAX = 2^(bits-1)-1,
//   functions sm_to_tc(bits) and tc_to_sm_sat. The functions are reused by the adder
//   and butterfly stages.
//  One sub-module, sm_sat_pack: S2 combinational |d|/clip/sign/zero-normalise logic.
//   Handshake control stays in this module.
// TESTING  (bits=16, fix_bit=7; 1.0 = 0x0080)
//  1. 0x0180 - 0x0080 (3.0-1.0), OUT_READY=1 -> OUTPUT=0x0100, SAT=0, OUT_VALID
//     exactly 2 cycles after accept.
//  2. 0x0080 - 0x0180 -> 0x8100. 0x8080 - 0x8180 (-1-(-3)) -> 0x0100.
//     0x8080 - 0x0080 -> 0x8100.
//  3. 0x7FFF - 0xFFFF -> 0x7FFF, SAT=1. 0xFFFF - 0x7FFF -> 0xFFFF, SAT=1.
//     0x4000 - 0xC000 -> 0x7FFF, SAT=1.
//  4. 0x8000 - 0x0000 -> 0x0000. 0x0080 - 0x0080 -> 0x0000. Never 0x8000 out, SAT=0.
//  5. Back-to-back stream of 6 pairs with OUT_READY low for 4 cycles mid-stream ->
//     IN_READY drops after 2 held, OUTPUT stable while stalled, all 6 results in order.
//  6. RST high 1 cycle with 2 pairs in flight -> OUT_VALID=0 next cycle, those results
//     never appear. Next pair after reset emerges with 2-cycle latency.

Source files
------------

// File: rtl/fft_fixed_pkg.sv
// Shared sign-magnitude fixed-point helpers for the FFT butterfly datapath.
// Functions work on a fixed maximum width; callers pass their word width w
// (w <= MAX_W) and truncate the result to w bits.
package fft_fixed_pkg;

  localparam int BITS    = 16;
  localparam int FIX_BIT = 7;
  localparam int SM_MAX  = (1 << (BITS - 1)) - 1;
  localparam int MAX_W   = 32;

  typedef logic signed [MAX_W:0] tc_t;
  typedef logic        [MAX_W-1:0] sm_t;

  // Sign-magnitude word of width w to two's complement; -0 maps to 0.
  function automatic tc_t sm_to_tc(input sm_t x, input int w);
    sm_t sign_bit;
    sm_t mag_mask;
    tc_t t;
    sign_bit = sm_t'(1) << (w - 1);
    mag_mask = sign_bit - sm_t'(1);
    t        = tc_t'({1'b0, x & mag_mask});
    return ((x & sign_bit) != '0) ? -t : t;
  endfunction

  function automatic tc_t tc_abs(input tc_t d);
    return d[MAX_W] ? -d : d;
  endfunction

  // True when |d| exceeds the largest magnitude a w-bit word can hold.
  function automatic logic sm_sat_flag(input tc_t d, input int w);
    sm_t smax;
    smax = (sm_t'(1) << (w - 1)) - sm_t'(1);
    return tc_abs(d) > tc_t'({1'b0, smax});
  endfunction

  // Two's complement to w-bit sign-magnitude, clipping to full scale.
  // A zero result always comes out as +0.
  function automatic sm_t tc_to_sm_sat(input tc_t d, input int w);
    sm_t sign_bit;
    sm_t smax;
    sm_t mag;
    tc_t a;
    sign_bit = sm_t'(1) << (w - 1);
    smax     = sign_bit - sm_t'(1);
    a        = tc_abs(d);
    if (a > tc_t'({1'b0, smax})) mag = smax;
    else                         mag = a[MAX_W-1:0];
    return d[MAX_W] ? (mag | sign_bit) : mag;
  endfunction

endpackage

// File: rtl/sm_sat_pack.sv
// Packing stage: two's complement difference to clipped sign-magnitude word.
module sm_sat_pack
  import fft_fixed_pkg::*;
#(
  parameter int bits = BITS
) (
  input  logic signed [bits:0]   d,
  output logic        [bits-1:0] sm,
  output logic                   sat
);

  // Magnitude, clip, sign and +0 normalisation in one combinational step
  always_comb begin
    sm  = bits'(tc_to_sm_sat(tc_t'(d), bits));
    sat = sm_sat_flag(tc_t'(d), bits);
  end

endmodule

// File: rtl/sm_subtractor_pipe.sv
// Two-stage flow-controlled sign-magnitude subtractor, OUTPUT = INPUT0 - INPUT1.
// S1 holds the exact two's complement difference, S2 the packed result.
module sm_subtractor_pipe
  import fft_fixed_pkg::*;
#(
  parameter int fix_bit = FIX_BIT,
  parameter int bits    = BITS
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [bits-1:0] INPUT0,
  input  logic [bits-1:0] INPUT1,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [bits-1:0] OUTPUT,
  output logic            SAT
);

  if (bits < 4 || bits > MAX_W) begin : g_bad_bits
    $error("sm_subtractor_pipe: bits out of supported range");
  end
  if (fix_bit < 0 || fix_bit > bits - 1) begin : g_bad_fix_bit
    $error("sm_subtractor_pipe: fix_bit must fit in the magnitude field");
  end

  logic                   vld_p1;
  logic                   vld_p2;
  logic                   ld_p1;
  logic                   ld_p2;
  logic signed [bits:0]   d_p1;
  logic        [bits-1:0] sm_p2;
  logic                   sat_p2;
  logic        [bits-1:0] pack_sm;
  logic                   pack_sat;

  // S2 refills when it is empty or its word leaves this cycle; S1 refills
  // when it is empty or its word moves into S2.
  assign ld_p2    = vld_p1 & (~vld_p2 | OUT_READY);
  assign ld_p1    = ~vld_p1 | ld_p2;
  assign IN_READY = RST | ~vld_p1 | ~vld_p2 | OUT_READY;

  // Stage-valid flags; reset drops whatever is in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p1) vld_p1 <= IN_VALID;
      if (ld_p2)          vld_p2 <= 1'b1;
      else if (OUT_READY) vld_p2 <= 1'b0;
    end
  end

  // ---- p0 -> p1: exact difference, cannot overflow at bits+1 ----
  always_ff @(posedge CLK) begin
    if (ld_p1 && IN_VALID)
      d_p1 <= (bits+1)'(sm_to_tc(sm_t'(INPUT0), bits) - sm_to_tc(sm_t'(INPUT1), bits));
  end

  sm_sat_pack #(
    .bits (bits)
  ) u_pack (
    .d   (d_p1),
    .sm  (pack_sm),
    .sat (pack_sat)
  );

  // ---- p1 -> p2: packed sign-magnitude word, held while stalled ----
  always_ff @(posedge CLK) begin
    if (ld_p2) begin
      sm_p2  <= pack_sm;
      sat_p2 <= pack_sat;
    end
  end

  // Outputs read as zero whenever nothing valid is presented
  assign OUT_VALID = vld_p2;
  assign OUTPUT    = vld_p2 ? sm_p2 : '0;
  assign SAT       = vld_p2 & sat_p2;

endmodule

// File: tb/tb_sm_subtractor_pipe.sv
// Scoreboard bench for sm_subtractor_pipe (bits=16, fix_bit=7).
module tb_sm_subtractor_pipe;

  localparam int BITS = 16;
  localparam int MAXM = (1 << (BITS - 1)) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in0;
  logic [BITS-1:0] in1;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out;
  logic            sat;

  always #5 clk = ~clk;

  sm_subtractor_pipe #(
    .fix_bit (7),
    .bits    (BITS)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .INPUT0    (in0),
    .INPUT1    (in1),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUTPUT    (out),
    .SAT       (sat)
  );

  typedef struct {
    logic [BITS-1:0] res;
    logic            s;
    int              acc_cyc;
    bit              chk_lat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int occ    = 0;
  logic [BITS-1:0] specials [6] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h8001};

  // Cycle count and number of accepted-but-not-emitted pairs
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) occ <= 0;
    else     occ <= occ + int'(in_valid & in_ready) - int'(out_valid & out_ready);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: operands as signed integers, subtract, clip magnitude, +0 for zero
  function automatic void ref_sub(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                  output logic [BITS-1:0] o, output logic s);
    int va, vb, d, m;
    va = int'(a[BITS-2:0]);
    if (a[BITS-1]) va = -va;
    vb = int'(b[BITS-2:0]);
    if (b[BITS-1]) vb = -vb;
    d = va - vb;
    m = (d < 0) ? -d : d;
    s = (m > MAXM);
    if (s) m = MAXM;
    if (m == 0) o = '0;
    else begin
      o = m[BITS-1:0];
      o[BITS-1] = (d < 0);
    end
  endfunction

  function automatic logic [BITS-1:0] rnd_op();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return BITS'($urandom);
  endfunction

  // One cycle of stimulus; pushes the expected result when the pair is accepted
  task automatic step(input bit iv, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                      input bit ordy, input bit r, input bit lat,
                      input bit hx, input logic [BITS-1:0] xr, input bit xs,
                      output bit fired);
    exp_t e;
    logic [BITS-1:0] o;
    logic s;
    @(negedge clk);
    in_valid  = iv;
    in0       = a;
    in1       = b;
    out_ready = ordy;
    rst       = r;
    #1;
    chk("in_ready", 32'(in_ready), 32'(r | (occ < 2) | ordy));
    fired = iv & in_ready & !r;
    if (r) q.delete();
    if (fired) begin
      ref_sub(a, b, o, s);
      e.res     = hx ? xr : o;
      e.s       = hx ? xs : s;
      e.acc_cyc = cyc;
      e.chk_lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    bit f;
    for (int i = 0; i < 20; i++) begin
      step(0, '0, '0, 1, 0, 0, 0, '0, 0, f);
      if (q.size() == 0) break;
    end
    step(0, '0, '0, 1, 0, 0, 0, '0, 0, f);
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  // Monitor: compares every emitted word against the scoreboard head
  initial begin : monitor
    exp_t e;
    bit prev_stall = 0;
    logic [BITS-1:0] prev_out = '0;
    logic prev_sat = 0;
    forever begin
      @(negedge clk);
      #2;
      if (prev_stall) begin
        chk("stall_hold_vld", 32'(out_valid), 1);
        chk("stall_hold_out", 32'(out), 32'(prev_out));
        chk("stall_hold_sat", 32'(sat), 32'(prev_sat));
      end
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h with no pending result", out);
        end else begin
          e = q.pop_front();
          chk("result", 32'(out), 32'(e.res));
          chk("sat", 32'(sat), 32'(e.s));
          if (e.chk_lat) chk("latency", 32'(cyc - e.acc_cyc), 2);
        end
      end
      prev_stall = !rst && out_valid && !out_ready;
      prev_out   = out;
      prev_sat   = sat;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [BITS-1:0] da [10] = '{16'h0180, 16'h0080, 16'h8080, 16'h8080, 16'h7FFF,
                                 16'hFFFF, 16'h4000, 16'h8000, 16'h0080, 16'h8000};
    logic [BITS-1:0] db [10] = '{16'h0080, 16'h0180, 16'h8180, 16'h0080, 16'hFFFF,
                                 16'h7FFF, 16'hC000, 16'h0000, 16'h0080, 16'h8000};
    logic [BITS-1:0] xr [10] = '{16'h0100, 16'h8100, 16'h0100, 16'h8100, 16'h7FFF,
                                 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    bit xs [10] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    logic [BITS-1:0] sa [6];
    logic [BITS-1:0] sb [6];
    bit f;
    int idx, t, low_seen;

    in_valid = 0; in0 = '0; in1 = '0; out_ready = 1; rst = 1;
    step(0, '0, '0, 1, 1, 0, 0, '0, 0, f);
    step(0, '0, '0, 1, 1, 0, 0, '0, 0, f);
    step(0, '0, '0, 1, 0, 0, 0, '0, 0, f);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_output", 32'(out), 0);
    chk("rst_sat", 32'(sat), 0);

    // Directed arithmetic cases, back to back from an empty pipe
    for (int i = 0; i < 10; i++) begin
      f = 0;
      for (int k = 0; k < 5 && !f; k++)
        step(1, da[i], db[i], 1, 0, 1, 1, xr[i], xs[i], f);
    end
    drain();

    // Six-pair stream with OUT_READY low for 4 cycles in the middle
    for (int i = 0; i < 6; i++) begin
      sa[i] = rnd_op();
      sb[i] = rnd_op();
    end
    idx = 0; t = 0; low_seen = 0;
    while (idx < 6 && t < 40) begin
      step(1, sa[idx], sb[idx], !(t >= 2 && t < 6), 0, 0, 0, '0, 0, f);
      if (!in_ready) low_seen++;
      if (f) idx++;
      t++;
    end
    chk("stream_all_accepted", 32'(idx), 6);
    chk("stall_in_ready_low", 32'(low_seen > 0), 1);
    drain();

    // Reset with two pairs in flight; RST together with IN_VALID transfers nothing
    step(1, 16'h0100, 16'h0080, 0, 0, 0, 0, '0, 0, f);
    step(1, 16'h0200, 16'h0080, 0, 0, 0, 0, '0, 0, f);
    chk("preload_depth", 32'(q.size()), 2);
    step(1, 16'h0300, 16'h0080, 1, 1, 0, 0, '0, 0, f);
    step(0, '0, '0, 1, 0, 0, 0, '0, 0, f);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    step(1, 16'h0180, 16'h8080, 1, 0, 1, 1, 16'h0200, 0, f);
    chk("post_rst_accept", 32'(f), 1);
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), $urandom_range(0, 3) != 0,
           0, 0, 0, '0, 0, f);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
